hilo_mult_unit: RTL and testbench

//  Multi-cycle multiply/accumulate unit with HI/LO registers; executes the ops that ALU control sends to the multiply path.

---
 rtl/mul_pkg.sv | 28 ++
 rtl/mult_shift_add_core.sv | 46 ++++
 rtl/hilo_mult_unit.sv | 135 +++++++++++++
 tb/tb_hilo_mult_unit.sv | 165 ++++++++++++++++
 4 files changed

// File: rtl/mul_pkg.sv
// Shared encodings for the multiply path: MulOp codes (also used by ALU
// control) and the sequencing states of the HI/LO multiply unit.
package mul_pkg;

  typedef enum logic [2:0] {
    MUL_OP_MUL   = 3'd0,
    MUL_OP_MULT  = 3'd1,
    MUL_OP_MULTU = 3'd2,
    MUL_OP_MADD  = 3'd3,
    MUL_OP_MSUB  = 3'd4,
    MUL_OP_MTHI  = 3'd5,
    MUL_OP_MTLO  = 3'd6,
    MUL_OP_NOP   = 3'd7
  } mul_op_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIN  = 2'd2
  } mul_state_e;

  // Signed ops take operand magnitudes and carry the product sign separately.
  function automatic logic op_is_signed(input mul_op_e op);
    return (op == MUL_OP_MUL) || (op == MUL_OP_MULT) ||
           (op == MUL_OP_MADD) || (op == MUL_OP_MSUB);
  endfunction

endpackage

// File: rtl/mult_shift_add_core.sv
// Radix-2 shift-add unsigned multiplier: one partial product per step.
module mult_shift_add_core #(
  parameter int WIDTH = 32
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_load,
  input  logic               i_step,
  input  logic [WIDTH-1:0]   i_mcand,
  input  logic [WIDTH-1:0]   i_mplier,
  output logic [2*WIDTH-1:0] o_acc,
  output logic               o_last
);

  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  logic [CNT_W-1:0]   r_cnt;
  logic [2*WIDTH-1:0] r_mcand;
  logic [WIDTH-1:0]   r_mplier;
  logic [2*WIDTH-1:0] r_acc;

  // Step counter; the step taken while o_last is high is the final one.
  always_ff @(posedge i_clk) begin
    if (i_rst)       r_cnt <= '0;
    else if (i_load) r_cnt <= '0;
    else if (i_step) r_cnt <= r_cnt + 1'b1;
  end

  // Shift registers and accumulator: mcand shifts left so it always equals
  // the original multiplicand << count.
  always_ff @(posedge i_clk) begin
    if (i_load) begin
      r_mcand  <= {{WIDTH{1'b0}}, i_mcand};
      r_mplier <= i_mplier;
      r_acc    <= '0;
    end else if (i_step) begin
      if (r_mplier[0]) r_acc <= r_acc + r_mcand;
      r_mcand  <= r_mcand << 1;
      r_mplier <= r_mplier >> 1;
    end
  end

  assign o_acc  = r_acc;
  assign o_last = (r_cnt == CNT_W'(WIDTH-1));

endmodule

// File: rtl/hilo_mult_unit.sv
// Multi-cycle multiply/accumulate unit with HI/LO registers. Holds the
// sequencing FSM, sign preparation, commit logic and architectural state.
module hilo_mult_unit
  import mul_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             Start,
  input  logic [2:0]       MulOp,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             Busy,
  output logic             Done,
  output logic [WIDTH-1:0] Result,
  output logic [WIDTH-1:0] HI,
  output logic [WIDTH-1:0] LO
);

  mul_state_e         r_state, w_next;
  mul_op_e            r_op;
  logic               r_neg;
  logic               r_done;
  logic [WIDTH-1:0]   r_hi, r_lo, r_result;

  mul_op_e            w_op_in;
  logic               w_load, w_step, w_commit, w_mov, w_last;
  logic [WIDTH-1:0]   w_opa, w_opb;
  logic [2*WIDTH-1:0] w_acc, w_prod;

  // Magnitude of a two's complement value; the most-negative value maps to
  // itself, which is correct when read as unsigned.
  function automatic logic [WIDTH-1:0] mag(input logic [WIDTH-1:0] v);
    logic signed [WIDTH-1:0] s;
    s = v;
    return s[WIDTH-1] ? WIDTH'(-s) : v;
  endfunction

  assign w_op_in = mul_op_e'(MulOp);
  assign w_opa   = op_is_signed(w_op_in) ? mag(A) : A;
  assign w_opb   = op_is_signed(w_op_in) ? mag(B) : B;

  mult_shift_add_core #(.WIDTH(WIDTH)) u_core (
    .i_clk    (Clk),
    .i_rst    (Reset),
    .i_load   (w_load),
    .i_step   (w_step),
    .i_mcand  (w_opa),
    .i_mplier (w_opb),
    .o_acc    (w_acc),
    .o_last   (w_last)
  );

  assign w_prod = r_neg ? (~w_acc + 1'b1) : w_acc;

  // State register.
  always_ff @(posedge Clk) begin
    if (Reset) r_state <= IDLE;
    else       r_state <= w_next;
  end

  // Next-state and per-cycle control decode.
  always_comb begin
    w_next   = r_state;
    w_load   = 1'b0;
    w_step   = 1'b0;
    w_commit = 1'b0;
    w_mov    = 1'b0;
    case (r_state)
      IDLE: begin
        if (Start) begin
          case (w_op_in)
            MUL_OP_MTHI, MUL_OP_MTLO: w_mov = 1'b1;
            MUL_OP_NOP: ;
            default: begin
              w_load = 1'b1;
              w_next = RUN;
            end
          endcase
        end
      end
      RUN: begin
        w_step = 1'b1;
        if (w_last) w_next = FIN;
      end
      FIN: begin
        w_commit = 1'b1;
        w_next   = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  // Latch the op and product sign at accept time.
  always_ff @(posedge Clk) begin
    if (w_load) begin
      r_op  <= w_op_in;
      r_neg <= op_is_signed(w_op_in) & (A[WIDTH-1] ^ B[WIDTH-1]);
    end
  end

  // Architectural HI/LO/Result: direct moves at accept, products at commit.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_hi     <= '0;
      r_lo     <= '0;
      r_result <= '0;
    end else if (w_mov) begin
      if (w_op_in == MUL_OP_MTHI) r_hi <= A;
      else                        r_lo <= A;
    end else if (w_commit) begin
      case (r_op)
        MUL_OP_MULT, MUL_OP_MULTU: {r_hi, r_lo} <= w_prod;
        MUL_OP_MADD:               {r_hi, r_lo} <= {r_hi, r_lo} + w_prod;
        MUL_OP_MSUB:               {r_hi, r_lo} <= {r_hi, r_lo} - w_prod;
        MUL_OP_MUL:                r_result     <= w_prod[WIDTH-1:0];
        default: ;
      endcase
    end
  end

  // Done pulses for one cycle after a commit or a HI/LO move.
  always_ff @(posedge Clk) begin
    if (Reset) r_done <= 1'b0;
    else       r_done <= w_commit | w_mov;
  end

  assign Busy   = (r_state != IDLE);
  assign Done   = r_done;
  assign Result = r_result;
  assign HI     = r_hi;
  assign LO     = r_lo;

endmodule

// File: tb/tb_hilo_mult_unit.sv
// Directed testbench for hilo_mult_unit with hand-computed expectations.
module tb_hilo_mult_unit;
  import mul_pkg::*;

  localparam int WIDTH = 32;

  logic             Clk = 1'b0;
  logic             Reset;
  logic             Start;
  logic [2:0]       MulOp;
  logic [WIDTH-1:0] A, B;
  logic             Busy, Done;
  logic [WIDTH-1:0] Result, HI, LO;

  int n_tests = 0;
  int n_fail  = 0;

  hilo_mult_unit #(.WIDTH(WIDTH)) dut (
    .Clk    (Clk),
    .Reset  (Reset),
    .Start  (Start),
    .MulOp  (MulOp),
    .A      (A),
    .B      (B),
    .Busy   (Busy),
    .Done   (Done),
    .Result (Result),
    .HI     (HI),
    .LO     (LO)
  );

  always #5 Clk = ~Clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Present one op for a single accept edge; returns at the negedge after it.
  task automatic issue(input mul_op_e op, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
    @(negedge Clk);
    MulOp = op; A = a; B = b; Start = 1'b1;
    @(negedge Clk);
    Start = 1'b0;
  endtask

  // Wait (bounded) for Done, counting cycles with Busy high on the way.
  task automatic wait_done(input string tag, output int busy_cyc);
    busy_cyc = 0;
    for (int i = 0; i < 100 && !Done; i++) begin
      if (Busy) busy_cyc++;
      @(negedge Clk);
    end
    if (!Done) check({tag, "_timeout"}, 64'(Done), 64'd1);
  endtask

  task automatic run_op(input string tag, input mul_op_e op,
                        input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                        output int busy_cyc);
    issue(op, a, b);
    wait_done(tag, busy_cyc);
    @(negedge Clk);
  endtask

  int cyc;
  int seen_done;

  initial begin
    Reset = 1'b1; Start = 1'b0; MulOp = 3'd7; A = '0; B = '0;
    repeat (3) @(negedge Clk);
    Reset = 1'b0;
    check("rst_busy", 64'(Busy), 64'd0);
    check("rst_done", 64'(Done), 64'd0);
    check("rst_result", 64'(Result), 64'd0);
    check("rst_hi", 64'(HI), 64'd0);
    check("rst_lo", 64'(LO), 64'd0);

    // MULTU max*max with timing and single Done pulse
    issue(MUL_OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF);
    wait_done("multu", cyc);
    check("multu_busy_cycles", 64'(cyc), 64'd33);
    check("multu_busy_at_done", 64'(Busy), 64'd0);
    @(negedge Clk);
    check("multu_done_once", 64'(Done), 64'd0);
    check("multu_hilo", {HI, LO}, 64'hFFFFFFFE_00000001);

    run_op("mult_neg", MUL_OP_MULT, 32'hFFFFFFFD, 32'd7, cyc);
    check("mult_neg_hilo", {HI, LO}, 64'hFFFFFFFF_FFFFFFEB);

    run_op("mult_min", MUL_OP_MULT, 32'h80000000, 32'h80000000, cyc);
    check("mult_min_hilo", {HI, LO}, 64'h40000000_00000000);

    // Moves, then accumulate / subtract
    issue(MUL_OP_MTHI, 32'd0, 32'd0);
    check("mthi_done", 64'(Done), 64'd1);
    check("mthi_busy", 64'(Busy), 64'd0);
    run_op("mtlo", MUL_OP_MTLO, 32'd10, 32'd0, cyc);
    check("mtlo_hilo", {HI, LO}, 64'h00000000_0000000A);
    run_op("madd", MUL_OP_MADD, 32'd4, 32'd5, cyc);
    check("madd_hilo", {HI, LO}, 64'h00000000_0000001E);
    run_op("msub", MUL_OP_MSUB, 32'd6, 32'd6, cyc);
    check("msub_hilo", {HI, LO}, 64'hFFFFFFFF_FFFFFFFA);

    // MUL writes Result only
    run_op("mul_wrap", MUL_OP_MUL, 32'h00010000, 32'h00010000, cyc);
    check("mul_wrap_result", 64'(Result), 64'd0);
    check("mul_wrap_hilo", {HI, LO}, 64'hFFFFFFFF_FFFFFFFA);
    run_op("mul_neg", MUL_OP_MUL, 32'hFFFFFFFE, 32'd3, cyc);
    check("mul_neg_result", 64'(Result), 64'h00000000_FFFFFFFA);

    // Op 7: no state change, no Done
    issue(MUL_OP_NOP, 32'h1111, 32'h2222);
    check("nop_done", 64'(Done), 64'd0);
    check("nop_busy", 64'(Busy), 64'd0);
    check("nop_hilo", {HI, LO}, 64'hFFFFFFFF_FFFFFFFA);

    // Start during Busy is ignored
    issue(MUL_OP_MULTU, 32'd3, 32'd5);
    repeat (4) @(negedge Clk);
    MulOp = MUL_OP_MTHI; A = 32'h1234; B = 32'h9; Start = 1'b1;
    @(negedge Clk);
    MulOp = MUL_OP_MULT; A = 32'h7777; Start = 1'b1;
    @(negedge Clk);
    Start = 1'b0;
    wait_done("ignore", cyc);
    check("ignore_busy_cycles", 64'(cyc), 64'd27);
    check("ignore_hilo", {HI, LO}, 64'h00000000_0000000F);

    // Start in the Done cycle is accepted
    MulOp = MUL_OP_MULTU; A = 32'd2; B = 32'd2; Start = 1'b1;
    @(negedge Clk);
    Start = 1'b0;
    check("b2b_busy", 64'(Busy), 64'd1);
    wait_done("b2b", cyc);
    @(negedge Clk);
    check("b2b_hilo", {HI, LO}, 64'h00000000_00000004);

    // Reset mid-RUN aborts the op
    run_op("pre_abort", MUL_OP_MUL, 32'd7, 32'd9, cyc);
    check("pre_abort_result", 64'(Result), 64'd63);
    issue(MUL_OP_MULT, 32'd100, 32'd200);
    repeat (9) @(negedge Clk);
    Reset = 1'b1;
    @(negedge Clk);
    Reset = 1'b0;
    check("abort_busy", 64'(Busy), 64'd0);
    check("abort_done", 64'(Done), 64'd0);
    check("abort_hilo", {HI, LO}, 64'd0);
    check("abort_result", 64'(Result), 64'd0);
    seen_done = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge Clk);
      if (Done || Busy) seen_done++;
    end
    check("abort_no_done", 64'(seen_done), 64'd0);
    check("abort_hilo_hold", {HI, LO}, 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
